dma_priority_encoder: RTL and testbench

DMA_PRIORITY_ENCODER -- requirements
Module: dma_priority_encoder

---
 rtl/dma_priority_encoder.sv | 145 ++++++++++++++
 tb/tb_dma_priority_encoder.sv | 397 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_priority_encoder.sv
// DMA request synchronizer, channel arbiter and grant FSM.
// Define DMA_ROTATING_PRIORITY_EN to enable rotating priority; otherwise fixed.
module dma_priority_encoder #(
   parameter int unsigned DREQ_SYNC_STAGES = 2
) (
   input  logic       CLK,
   input  logic       RESET,
   input  logic       MasterClear,
   input  logic [3:0] DREQ,
   input  logic [3:0] RequestReg,
   input  logic [3:0] MaskReg,
   input  logic       CmdDisable,
   input  logic       CmdRotate,
   input  logic       CmdDreqLow,
   input  logic       ServiceDone,
   output logic       ValidReqID,
   output logic [1:0] ReqID,
   output logic [3:0] PendingReq
);

   localparam int unsigned ChainW = 4 * DREQ_SYNC_STAGES;

   typedef enum logic {StIdle, StGrant} state_e;

   state_e            r_state, w_state_d;
   logic              r_valid, w_valid_d;
   logic [1:0]        r_req_id, w_req_id_d;
   logic [3:0]        r_pend;
   logic [ChainW-1:0] r_chain, w_chain_d;
   logic [3:0]        w_sync, w_eff;
   logic [1:0]        w_winner;
   logic [1:0]        w_top;

   // Newest sample enters the low nibble; the oldest nibble is the synchronized request.
   always_comb begin
      w_chain_d = (r_chain << 4) | ChainW'(DREQ ^ {4{CmdDreqLow}});
   end

   assign w_sync = r_chain[ChainW-1 -: 4];
   assign w_eff  = (w_sync & ~MaskReg) | RequestReg;

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         r_chain <= '0;
         r_pend  <= '0;
      end else if (MasterClear) begin
         r_chain <= '0;
         r_pend  <= '0;
      end else begin
         r_chain <= w_chain_d;
         r_pend  <= w_sync | RequestReg;
      end
   end

`ifdef DMA_ROTATING_PRIORITY_EN
   logic [1:0] r_top, w_top_d;

   assign w_top = CmdRotate ? r_top : 2'd0;

   always_comb begin
      w_top_d = r_top;
      if (!CmdRotate) begin
         w_top_d = 2'd0;
      end else if (r_state == StGrant && ServiceDone) begin
         w_top_d = r_req_id + 2'd1;
      end
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         r_top <= 2'd0;
      end else if (MasterClear) begin
         r_top <= 2'd0;
      end else begin
         r_top <= w_top_d;
      end
   end
`else
   logic w_rotate_unused;

   assign w_rotate_unused = CmdRotate;
   assign w_top           = 2'd0;
`endif

   // Scan lowest priority first so the highest-priority requester overwrites.
   always_comb begin
      logic [1:0] w_idx;
      w_idx    = 2'd0;
      w_winner = 2'd0;
      for (int k = 3; k >= 0; k--) begin
         w_idx = w_top + 2'(k);
         if (w_eff[w_idx]) begin
            w_winner = w_idx;
         end
      end
   end

   always_comb begin
      w_state_d  = r_state;
      w_valid_d  = r_valid;
      w_req_id_d = r_req_id;
      unique case (r_state)
         StIdle: begin
            if (!CmdDisable && (w_eff != 4'd0)) begin
               w_state_d  = StGrant;
               w_valid_d  = 1'b1;
               w_req_id_d = w_winner;
            end else begin
               w_valid_d = 1'b0;
            end
         end
         StGrant: begin
            if (ServiceDone) begin
               w_state_d = StIdle;
               w_valid_d = 1'b0;
            end
         end
         default: begin
            w_state_d = StIdle;
            w_valid_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         r_state  <= StIdle;
         r_valid  <= 1'b0;
         r_req_id <= 2'd0;
      end else if (MasterClear) begin
         r_state  <= StIdle;
         r_valid  <= 1'b0;
         r_req_id <= 2'd0;
      end else begin
         r_state  <= w_state_d;
         r_valid  <= w_valid_d;
         r_req_id <= w_req_id_d;
      end
   end

   assign ValidReqID = r_valid;
   assign ReqID      = r_req_id;
   assign PendingReq = r_pend;

endmodule

// File: tb/tb_dma_priority_encoder.sv
// Self-checking bench for dma_priority_encoder: directed scenarios plus randomized
// traffic against a behavioural arbitration model.
module tb_dma_priority_encoder;

   localparam int N = 2;
`ifdef DMA_ROTATING_PRIORITY_EN
   localparam bit Rot = 1'b1;
`else
   localparam bit Rot = 1'b0;
`endif

   logic       CLK, RESET, MasterClear, CmdDisable, CmdRotate, CmdDreqLow, ServiceDone;
   logic [3:0] DREQ, RequestReg, MaskReg;
   logic       ValidReqID;
   logic [1:0] ReqID;
   logic [3:0] PendingReq;

   int total = 0;
   int bad   = 0;

   // Reference model state
   logic       m_valid;
   logic [1:0] m_id;
   int         m_top;
   logic [3:0] m_pend;
   logic [3:0] m_hist[$];

   dma_priority_encoder #(.DREQ_SYNC_STAGES(N)) dut (
      .CLK        (CLK),
      .RESET      (RESET),
      .MasterClear(MasterClear),
      .DREQ       (DREQ),
      .RequestReg (RequestReg),
      .MaskReg    (MaskReg),
      .CmdDisable (CmdDisable),
      .CmdRotate  (CmdRotate),
      .CmdDreqLow (CmdDreqLow),
      .ServiceDone(ServiceDone),
      .ValidReqID (ValidReqID),
      .ReqID      (ReqID),
      .PendingReq (PendingReq)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   function automatic logic [1:0] pick(input logic [3:0] e, input int top);
      for (int k = 0; k < 4; k++) begin
         int c;
         c = (top + k) % 4;
         if (e[c]) return 2'(c);
      end
      return 2'd0;
   endfunction

   task automatic model_clear();
      m_valid = 1'b0;
      m_id    = 2'd0;
      m_top   = 0;
      m_pend  = 4'd0;
      m_hist.delete();
   endtask

   // Advance the model by one rising edge using the inputs currently applied.
   task automatic model_edge();
      logic [3:0] s, e;
      bit rot;
      if (MasterClear) begin
         model_clear();
      end else begin
         s = (m_hist.size() >= N) ? m_hist[N-1] : 4'd0;
         e = (s & ~MaskReg) | RequestReg;
         rot = Rot && CmdRotate;
         m_pend = s | RequestReg;
         if (!m_valid) begin
            if (!CmdDisable && e != 4'd0) begin
               m_valid = 1'b1;
               m_id    = pick(e, rot ? m_top : 0);
            end
         end else if (ServiceDone) begin
            m_valid = 1'b0;
            if (rot) m_top = (int'(m_id) + 1) % 4;
         end
         if (!rot) m_top = 0;
         m_hist.push_front(DREQ ^ {4{CmdDreqLow}});
         if (m_hist.size() > 4) void'(m_hist.pop_back());
      end
   endtask

   task automatic tick();
      model_edge();
      @(posedge CLK);
      #1;
   endtask

   task automatic test_reset();
      RequestReg = 4'b0010;
      tick();
      #3;
      RESET = 1'b1;
      #1;
      model_clear();
      total++;
      if (ValidReqID !== 1'b0) begin
         bad++;
         $display("FAIL reset_valid got=%0b want=0", ValidReqID);
      end
      total++;
      if (ReqID !== 2'd0) begin
         bad++;
         $display("FAIL reset_id got=%0d want=0", ReqID);
      end
      total++;
      if (PendingReq !== 4'd0) begin
         bad++;
         $display("FAIL reset_pend got=%b want=0000", PendingReq);
      end
      RequestReg = 4'd0;
      @(posedge CLK);
      #1;
      RESET = 1'b0;
   endtask

   task automatic test_fixed();
      RequestReg = 4'b1010;
      tick();
      total++;
      if (ValidReqID !== 1'b1 || ReqID !== 2'd1) begin
         bad++;
         $display("FAIL fixed_first got v=%0b id=%0d want v=1 id=1", ValidReqID, ReqID);
      end
      ServiceDone = 1'b1;
      RequestReg  = 4'b1000;
      tick();
      ServiceDone = 1'b0;
      total++;
      if (ValidReqID !== 1'b0) begin
         bad++;
         $display("FAIL fixed_gap got v=%0b want v=0", ValidReqID);
      end
      tick();
      total++;
      if (ValidReqID !== 1'b1 || ReqID !== 2'd3) begin
         bad++;
         $display("FAIL fixed_second got v=%0b id=%0d want v=1 id=3", ValidReqID, ReqID);
      end
      ServiceDone = 1'b1;
      RequestReg  = 4'd0;
      tick();
      ServiceDone = 1'b0;
   endtask

   task automatic test_polarity();
      CmdDreqLow = 1'b1;
      DREQ       = 4'b1011;
      tick();
      tick();
      total++;
      if (ValidReqID !== 1'b0) begin
         bad++;
         $display("FAIL pol_early got v=%0b want v=0", ValidReqID);
      end
      tick();
      total++;
      if (ValidReqID !== 1'b1 || ReqID !== 2'd2 || PendingReq !== 4'b0100) begin
         bad++;
         $display("FAIL pol_grant got v=%0b id=%0d pend=%b want v=1 id=2 pend=0100",
                  ValidReqID, ReqID, PendingReq);
      end
      MaskReg     = 4'b0100;
      ServiceDone = 1'b1;
      tick();
      ServiceDone = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         total++;
         if (ValidReqID !== 1'b0 || PendingReq !== 4'b0100) begin
            bad++;
            $display("FAIL pol_masked got v=%0b pend=%b want v=0 pend=0100",
                     ValidReqID, PendingReq);
         end
      end
      DREQ = 4'b1111;
      repeat (3) tick();
      MaskReg = 4'd0;
   endtask

   task automatic test_hold();
      CmdDreqLow = 1'b0;
      DREQ       = 4'd0;
      RequestReg = 4'b0100;
      tick();
      RequestReg = 4'd0;
      CmdDisable = 1'b1;
      DREQ       = 4'b0001;
      for (int i = 0; i < 5; i++) begin
         MaskReg   = 4'($urandom_range(0, 15));
         CmdRotate = 1'($urandom_range(0, 1));
         tick();
         total++;
         if (ValidReqID !== 1'b1 || ReqID !== 2'd2) begin
            bad++;
            $display("FAIL hold cyc=%0d got v=%0b id=%0d want v=1 id=2", i, ValidReqID, ReqID);
         end
      end
      CmdRotate   = 1'b0;
      MaskReg     = 4'd0;
      ServiceDone = 1'b1;
      tick();
      ServiceDone = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         total++;
         if (ValidReqID !== 1'b0) begin
            bad++;
            $display("FAIL hold_disabled cyc=%0d got v=%0b want v=0", i, ValidReqID);
         end
      end
      DREQ = 4'd0;
      repeat (3) tick();
      CmdDisable = 1'b0;
   endtask

   task automatic test_service_idle();
      ServiceDone = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         total++;
         if (ValidReqID !== 1'b0) begin
            bad++;
            $display("FAIL sd_idle cyc=%0d got v=%0b want v=0", i, ValidReqID);
         end
      end
      ServiceDone = 1'b0;
   endtask

`ifdef DMA_ROTATING_PRIORITY_EN
   task automatic test_rotation();
      logic [1:0] exp_seq [5];
      exp_seq = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
      CmdRotate  = 1'b1;
      RequestReg = 4'b1111;
      for (int i = 0; i < 5; i++) begin
         tick();
         total++;
         if (ValidReqID !== 1'b1 || ReqID !== exp_seq[i]) begin
            bad++;
            $display("FAIL rotate step=%0d got v=%0b id=%0d want v=1 id=%0d",
                     i, ValidReqID, ReqID, exp_seq[i]);
         end
         ServiceDone = 1'b1;
         tick();
         ServiceDone = 1'b0;
      end
      // Top is now 1; ServiceDone in IDLE must leave it there.
      RequestReg  = 4'd0;
      ServiceDone = 1'b1;
      repeat (2) tick();
      ServiceDone = 1'b0;
      RequestReg  = 4'b1111;
      tick();
      total++;
      if (ValidReqID !== 1'b1 || ReqID !== 2'd1) begin
         bad++;
         $display("FAIL rotate_sd_idle got v=%0b id=%0d want v=1 id=1", ValidReqID, ReqID);
      end
      ServiceDone = 1'b1;
      RequestReg  = 4'd0;
      tick();
      ServiceDone = 1'b0;
      CmdRotate   = 1'b0;
      tick();
   endtask
`endif

   // Reach a grant of channel 3 (with Top=3 when rotation exists), then clear it.
   task automatic test_clear();
      for (int v = 0; v < 2; v++) begin
         CmdRotate  = 1'b1;
         RequestReg = 4'b1111;
         for (int j = 0; j < 3; j++) begin
            tick();
            ServiceDone = 1'b1;
            tick();
            ServiceDone = 1'b0;
         end
         RequestReg = 4'b1000;
         tick();
         total++;
         if (ValidReqID !== 1'b1 || ReqID !== 2'd3) begin
            bad++;
            $display("FAIL clear_setup v=%0d got v=%0b id=%0d want v=1 id=3",
                     v, ValidReqID, ReqID);
         end
         if (v == 0) begin
            MasterClear = 1'b1;
            ServiceDone = 1'b1;
            tick();
            MasterClear = 1'b0;
            ServiceDone = 1'b0;
         end else begin
            #3;
            RESET = 1'b1;
            #1;
            model_clear();
         end
         total++;
         if (ValidReqID !== 1'b0 || ReqID !== 2'd0 || PendingReq !== 4'd0) begin
            bad++;
            $display("FAIL clear_state v=%0d got v=%0b id=%0d pend=%b want v=0 id=0 pend=0000",
                     v, ValidReqID, ReqID, PendingReq);
         end
         if (v == 1) begin
            @(posedge CLK);
            #1;
            RESET = 1'b0;
         end
         RequestReg = 4'b1110;
         tick();
         total++;
         if (ValidReqID !== 1'b1 || ReqID !== 2'd1) begin
            bad++;
            $display("FAIL clear_restart v=%0d got v=%0b id=%0d want v=1 id=1",
                     v, ValidReqID, ReqID);
         end
         ServiceDone = 1'b1;
         RequestReg  = 4'd0;
         CmdRotate   = 1'b0;
         tick();
         ServiceDone = 1'b0;
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         RequestReg  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'd0;
         DREQ        = 4'($urandom_range(0, 15));
         MaskReg     = 4'($urandom_range(0, 15));
         CmdDisable  = ($urandom_range(0, 4) == 0);
         ServiceDone = ($urandom_range(0, 2) == 0);
         MasterClear = ($urandom_range(0, 49) == 0);
         if ($urandom_range(0, 19) == 0) CmdRotate = ~CmdRotate;
         if ($urandom_range(0, 29) == 0) CmdDreqLow = ~CmdDreqLow;
         tick();
         total++;
         if (ValidReqID !== m_valid) begin
            bad++;
            $display("FAIL rand_valid cyc=%0d got=%0b want=%0b", i, ValidReqID, m_valid);
         end
         if (m_valid) begin
            total++;
            if (ReqID !== m_id) begin
               bad++;
               $display("FAIL rand_id cyc=%0d got=%0d want=%0d", i, ReqID, m_id);
            end
         end
         total++;
         if (PendingReq !== m_pend) begin
            bad++;
            $display("FAIL rand_pend cyc=%0d got=%b want=%b", i, PendingReq, m_pend);
         end
      end
      MasterClear = 1'b0;
      ServiceDone = 1'b0;
   endtask

   initial begin
      RESET       = 1'b1;
      MasterClear = 1'b0;
      DREQ        = 4'd0;
      RequestReg  = 4'd0;
      MaskReg     = 4'd0;
      CmdDisable  = 1'b0;
      CmdRotate   = 1'b0;
      CmdDreqLow  = 1'b0;
      ServiceDone = 1'b0;
      model_clear();
      repeat (2) @(posedge CLK);
      #1;
      RESET = 1'b0;

      test_reset();
      test_fixed();
      test_polarity();
      test_hold();
      test_service_idle();
`ifdef DMA_ROTATING_PRIORITY_EN
      test_rotation();
`endif
      test_clear();
      test_random();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
